// File: rtl/timer_pkg.sv
// Shared definitions for the APB timer: register map, TCR/TSR bit positions,
// prescaler select encodings and the prescaler tick decoder.
package timer_pkg;

  // Register map
  localparam logic [7:0] AddrTdr  = 8'h00;
  localparam logic [7:0] AddrTcr  = 8'h01;
  localparam logic [7:0] AddrTsr  = 8'h02;
  localparam logic [7:0] AddrTcnt = 8'h03;

  // TCR field positions
  localparam int unsigned TcrLoadBit = 7;
  localparam int unsigned TcrDownBit = 5;
  localparam int unsigned TcrEnBit   = 4;

  // TSR flag positions
  localparam int unsigned TsrOvfBit = 0;
  localparam int unsigned TsrUdfBit = 1;

  // Prescaler select: tick every 2/4/8/16 clocks
  typedef enum logic [1:0] {
    CksDiv2  = 2'b00,
    CksDiv4  = 2'b01,
    CksDiv8  = 2'b10,
    CksDiv16 = 2'b11
  } cks_e;

  // Tick when the low bits of the free-running prescaler are all ones, so each
  // division ratio fires exactly once per period without restarting anything.
  function automatic logic cks_tick(input logic [3:0] presc, input cks_e cks);
    logic t;
    unique case (cks)
      CksDiv2:  t = presc[0];
      CksDiv4:  t = &presc[1:0];
      CksDiv8:  t = &presc[2:0];
      CksDiv16: t = &presc;
      default:  t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/timer_counter.sv
// 8-bit up/down counter with a free-running 4-bit prescaler. Load has priority
// over counting; ovf_o/udf_o pulse for one cycle on wrap.
module timer_counter
  import timer_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       load_i,
  input  logic       down_i,
  input  cks_e       cks_i,
  input  logic [7:0] load_val_i,
  output logic [7:0] cnt_o,
  output logic       ovf_o,
  output logic       udf_o
);

  logic [3:0] presc_q, presc_d;
  logic [7:0] cnt_q, cnt_d;
  logic       tick;

  assign presc_d = presc_q + 4'd1;
  assign tick    = cks_tick(presc_q, cks_i);
  assign cnt_o   = cnt_q;

  // Next counter value and wrap pulses
  always_comb begin
    cnt_d = cnt_q;
    ovf_o = 1'b0;
    udf_o = 1'b0;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && tick) begin
      if (down_i) begin
        cnt_d = cnt_q - 8'd1;
        udf_o = (cnt_q == 8'h00);
      end else begin
        cnt_d = cnt_q + 8'd1;
        ovf_o = (cnt_q == 8'hff);
      end
    end
  end

  // Prescaler and counter state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= 4'd0;
      cnt_q   <= 8'h00;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/timer_testbench.sv
// APB timer top: APB decode, wait-state generation and the TDR/TCR/TSR
// registers; the counter lives in timer_counter.
// Build option: define TIMER_IRQ_EN to drive tmr_ovf/tmr_udf from TSR;
// otherwise both interrupt outputs are tied low.
module timer_testbench
  import timer_pkg::*;
#(
  parameter int unsigned WAIT = 0
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  output logic       tmr_ovf,
  output logic       tmr_udf
);

  localparam int unsigned WaitW = (WAIT > 0) ? $clog2(WAIT + 1) : 1;

  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic [7:0]       tdr_q, tcr_q;
  logic [1:0]       tsr_q, tsr_d;
  logic [7:0]       cnt;
  logic [7:0]       rdata;
  logic             access, addr_ok, wr;
  logic             ovf_set, udf_set, tsr_wr;

  // pready is constant 1 when WAIT is 0 since the counter never leaves 0
  assign pready  = (wait_cnt_q == WaitW'(WAIT));
  // Gated by presetn so pslverr/prdata stay low while reset is held
  assign access  = presetn & psel & penable & pready;
  assign addr_ok = (paddr <= AddrTcnt);
  assign wr      = access & pwrite & addr_ok;
  assign tsr_wr  = wr & (paddr == AddrTsr);

  // Count wait states during the access phase; cleared once the transfer ends
  always_comb begin
    wait_cnt_d = '0;
    if (psel && penable && !pready) begin
      wait_cnt_d = wait_cnt_q + WaitW'(1);
    end
  end

  // Status flags: hardware set wins over a software write-0 clear
  always_comb begin
    tsr_d = tsr_q;
    tsr_d[TsrOvfBit] = ovf_set | (tsr_q[TsrOvfBit] & ~(tsr_wr & ~pwdata[TsrOvfBit]));
    tsr_d[TsrUdfBit] = udf_set | (tsr_q[TsrUdfBit] & ~(tsr_wr & ~pwdata[TsrUdfBit]));
  end

  // Register file and wait counter
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wait_cnt_q <= '0;
      tdr_q      <= 8'h00;
      tcr_q      <= 8'h00;
      tsr_q      <= 2'b00;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      tsr_q      <= tsr_d;
      if (wr && paddr == AddrTdr) tdr_q <= pwdata;
      if (wr && paddr == AddrTcr) tcr_q <= pwdata;
    end
  end

  timer_counter u_counter (
    .clk_i      (pclk),
    .rst_ni     (presetn),
    .en_i       (tcr_q[TcrEnBit]),
    .load_i     (tcr_q[TcrLoadBit]),
    .down_i     (tcr_q[TcrDownBit]),
    .cks_i      (cks_e'(tcr_q[1:0])),
    .load_val_i (tdr_q),
    .cnt_o      (cnt),
    .ovf_o      (ovf_set),
    .udf_o      (udf_set)
  );

  // Read mux; unmapped addresses read 0
  always_comb begin
    rdata = 8'h00;
    unique case (paddr)
      AddrTdr:  rdata = tdr_q;
      AddrTcr:  rdata = tcr_q;
      AddrTsr:  rdata = {6'b0, tsr_q};
      AddrTcnt: rdata = cnt;
      default:  rdata = 8'h00;
    endcase
  end

  assign prdata  = (access && !pwrite && addr_ok) ? rdata : 8'h00;
  assign pslverr = access & ~addr_ok;

`ifdef TIMER_IRQ_EN
  assign tmr_ovf = tsr_q[TsrOvfBit];
  assign tmr_udf = tsr_q[TsrUdfBit];
`else
  assign tmr_ovf = 1'b0;
  assign tmr_udf = 1'b0;
`endif

endmodule

// File: tb/tb_timer_testbench.sv
// Directed bench for timer_testbench: one WAIT=0 and one WAIT=3 instance share
// the APB bus; use_w3 steers psel to one of them.
module tb_timer_testbench;

`ifdef TIMER_IRQ_EN
  localparam logic IrqEn = 1'b1;
`else
  localparam logic IrqEn = 1'b0;
`endif

  logic       pclk = 1'b0;
  logic       presetn = 1'b0;
  logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0] paddr = 8'h00, pwdata = 8'h00;
  logic       use_w3 = 1'b0;

  logic       psel0, psel1;
  logic [7:0] prdata0, prdata1, prdata_m;
  logic       pready0, pready1, pready_m;
  logic       pslverr0, pslverr1, pslverr_m;
  logic       ovf0, ovf1, udf0, udf1, ovf_m, udf_m;

  int n_total = 0;
  int n_pass = 0;
  int n_fail = 0;
  int last_waits = 0;
  logic       last_err;
  logic [7:0] rd;

  assign psel0     = psel & ~use_w3;
  assign psel1     = psel & use_w3;
  assign prdata_m  = use_w3 ? prdata1 : prdata0;
  assign pready_m  = use_w3 ? pready1 : pready0;
  assign pslverr_m = use_w3 ? pslverr1 : pslverr0;
  assign ovf_m     = use_w3 ? ovf1 : ovf0;
  assign udf_m     = use_w3 ? udf1 : udf0;

  always #5 pclk = ~pclk;

  timer_testbench #(.WAIT(0)) dut0 (
    .pclk(pclk), .presetn(presetn), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .pready(pready0),
    .pslverr(pslverr0), .tmr_ovf(ovf0), .tmr_udf(udf0)
  );

  timer_testbench #(.WAIT(3)) dut3 (
    .pclk(pclk), .presetn(presetn), .psel(psel1), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata1), .pready(pready1),
    .pslverr(pslverr1), .tmr_ovf(ovf1), .tmr_udf(udf1)
  );

  task automatic check(input string name, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%02h required 0x%02h", name, obs, exp);
    end
  endtask

  // Setup edge, access edge(s); data/err sampled just before the completing edge
  task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [7:0] data);
    int n;
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    n = 0;
    while (!pready_m && n < 20) begin
      @(negedge pclk);
      #1;
      n++;
    end
    if (n >= 20) check("pready_timeout", {7'b0, pready_m}, 8'h01);
    last_waits = n;
    last_err   = pslverr_m;
    rd         = prdata_m;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge pclk);
    presetn = 1'b0; psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    presetn = 1'b1;
  endtask

  initial begin
    // Reset state; psel held on an unmapped address must not raise pslverr
    psel = 1'b1; penable = 1'b1; paddr = 8'h05;
    repeat (2) @(negedge pclk);
    #1;
    check("rst_prdata", prdata0, 8'h00);
    check("rst_pslverr", {7'b0, pslverr0}, 8'h00);
    check("rst_pready_w0", {7'b0, pready0}, 8'h01);
    check("rst_irq", {6'b0, ovf0, udf0}, 8'h00);
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;
    apb_xfer(1'b0, 8'h03, 8'h00);
    check("rst_tcnt", rd, 8'h00);

    // Basic TCR write/read
    do_reset();
    apb_xfer(1'b1, 8'h01, 8'h10);
    check("tcr_wr_err", {7'b0, last_err}, 8'h00);
    apb_xfer(1'b0, 8'h01, 8'h00);
    check("tcr_rd", rd, 8'h10);
    check("tcr_rd_err", {7'b0, last_err}, 8'h00);

    // Enable / disable / enable. Edges counted from reset release: enabled on
    // edges 4..206 and 416..716, cks=00 ticks on even edges -> 102 + 151 = 253.
    do_reset();
    apb_xfer(1'b1, 8'h01, 8'h10);
    repeat (200) @(negedge pclk);
    apb_xfer(1'b1, 8'h01, 8'h00);
    apb_xfer(1'b0, 8'h03, 8'h00);
    check("cnt_at_disable", rd, 8'h66);
    repeat (200) @(negedge pclk);
    apb_xfer(1'b0, 8'h03, 8'h00);
    check("cnt_held", rd, 8'h66);
    apb_xfer(1'b1, 8'h01, 8'h10);
    repeat (299) @(negedge pclk);
    apb_xfer(1'b0, 8'h03, 8'h00);
    check("cnt_after_reenable", rd, 8'hfd);

    // Overflow: load 0xFE (edge 9), ticks at edges 10 -> FF, 12 -> 00
    do_reset();
    apb_xfer(1'b1, 8'h00, 8'hfe);
    apb_xfer(1'b1, 8'h01, 8'h90);
    apb_xfer(1'b1, 8'h01, 8'h10);
    @(negedge pclk);
    apb_xfer(1'b0, 8'h03, 8'h00);
    check("ovf_cnt", rd, 8'h00);
    apb_xfer(1'b0, 8'h02, 8'h00);
    check("ovf_tsr", rd, 8'h01);
    check("ovf_irq", {7'b0, ovf_m}, {7'b0, IrqEn});
    apb_xfer(1'b1, 8'h02, 8'h03);
    apb_xfer(1'b0, 8'h02, 8'h00);
    check("tsr_w1_noeffect", rd, 8'h01);
    apb_xfer(1'b1, 8'h02, 8'h00);
    apb_xfer(1'b0, 8'h02, 8'h00);
    check("tsr_cleared", rd, 8'h00);
    check("ovf_irq_cleared", {7'b0, ovf_m}, 8'h00);

    // Underflow: load 0x01, cks=11 ticks at edges 16 (->00) and 32 (->FF)
    do_reset();
    apb_xfer(1'b1, 8'h00, 8'h01);
    apb_xfer(1'b1, 8'h01, 8'h80);
    apb_xfer(1'b1, 8'h01, 8'h33);
    repeat (30) @(negedge pclk);
    apb_xfer(1'b0, 8'h03, 8'h00);
    check("udf_cnt", rd, 8'hff);
    apb_xfer(1'b0, 8'h02, 8'h00);
    check("udf_tsr", rd, 8'h02);
    check("udf_irq", {7'b0, udf_m}, {7'b0, IrqEn});
    apb_xfer(1'b0, 8'h01, 8'h00);
    check("tcr_readback_33", rd, 8'h33);

    // Wait states, spare TCR bits, unmapped and read-only addresses
    do_reset();
    use_w3 = 1'b1;
    apb_xfer(1'b1, 8'h01, 8'h4c);
    check("w3_wr_waits", 8'(last_waits), 8'd3);
    apb_xfer(1'b0, 8'h01, 8'h00);
    check("w3_tcr_spare_bits", rd, 8'h4c);
    check("w3_rd_waits", 8'(last_waits), 8'd3);
    apb_xfer(1'b0, 8'h05, 8'h00);
    check("w3_bad_rd_data", rd, 8'h00);
    check("w3_bad_rd_err", {7'b0, last_err}, 8'h01);
    check("w3_bad_rd_waits", 8'(last_waits), 8'd3);
    apb_xfer(1'b1, 8'h05, 8'haa);
    check("w3_bad_wr_err", {7'b0, last_err}, 8'h01);
    apb_xfer(1'b1, 8'h03, 8'h55);
    check("w3_tcnt_wr_err", {7'b0, last_err}, 8'h00);
    apb_xfer(1'b0, 8'h03, 8'h00);
    check("w3_tcnt_ro", rd, 8'h00);
    apb_xfer(1'b0, 8'h01, 8'h00);
    check("w3_tcr_untouched", rd, 8'h4c);

    // Reset mid-count and mid-transfer
    use_w3 = 1'b0;
    do_reset();
    apb_xfer(1'b1, 8'h00, 8'h5a);
    apb_xfer(1'b1, 8'h01, 8'h10);
    repeat (20) @(negedge pclk);
    apb_xfer(1'b0, 8'h03, 8'h00);
    check("pre_rst_counting", 8'(rd != 8'h00), 8'h01);
    use_w3 = 1'b1;
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h05;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    presetn = 1'b0;
    #1;
    check("midrst_pslverr", {7'b0, pslverr_m}, 8'h00);
    check("midrst_prdata", prdata_m, 8'h00);
    check("midrst_irq", {4'b0, ovf0, udf0, ovf1, udf1}, 8'h00);
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;
    apb_xfer(1'b0, 8'h00, 8'h00);
    check("postrst_w3_waits", 8'(last_waits), 8'd3);
    check("postrst_w3_tdr", rd, 8'h00);
    use_w3 = 1'b0;
    apb_xfer(1'b0, 8'h00, 8'h00);
    check("postrst_tdr", rd, 8'h00);
    apb_xfer(1'b0, 8'h01, 8'h00);
    check("postrst_tcr", rd, 8'h00);
    apb_xfer(1'b0, 8'h02, 8'h00);
    check("postrst_tsr", rd, 8'h00);
    apb_xfer(1'b0, 8'h03, 8'h00);
    check("postrst_tcnt", rd, 8'h00);
    check("postrst_outputs", {6'b0, ovf0, udf0}, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
